batch_cost_accumulator: RTL and testbench
=========================================

# batch_cost_accumulator

Downstream of `cost_calculator` in the training datapath. Consumes one 8-bit per-image cost per `calculation_complete` event and accumulates costs over a batch of `BATCH_SIZE` images. At batch end it reports the truncated average cost, the maximum cost, and a convergence flag to the training controller. Results are held under a ready/ack handshake.

## Interface
- `BATCH_SIZE`, default 16. Images per batch; must be a power of two, range 2..64.
- `COST_WIDTH`, default 8. Width of the per-image cost. Taken from the shared package.
- `clk` in 1. System clock.
- `n_rst` in 1. Reset, synchronous, active-low. All state is cleared on a rising `clk` edge while low.
- `clear` in 1. Synchronous soft clear. Identical effect to reset. Has priority over every other input.
- `cost_valid` in 1. Driven by `cost_calculator.calculation_complete`. May be a pulse or a held level. Only its rising edge counts.
- `cost_in` in `COST_WIDTH`. Driven by `cost_calculator.cost_output`. Sampled on the accepted edge.
- `threshold` in `COST_WIDTH`. Convergence threshold. Sampled at batch completion.
- `batch_ack` in 1. Controller acknowledges the reported batch.
- `batch_ready` out 1. Batch result is valid and held.
- `avg_cost` out `COST_WIDTH`. Average cost of the last completed batch.
- `max_cost` out `COST_WIDTH`. Maximum cost in the last completed batch.
- `converged` out 1. Set when `avg_cost <= threshold`.
- `overrun` out 1. A sample was dropped while waiting for ack.
- `sample_count` out `$clog2(BATCH_SIZE)`. Samples accepted in the current batch.

## Operation
- Edge detect: `cost_valid_q` is a register. A sample is accepted when `accept = cost_valid & ~cost_valid_q`. A level held for N cycles produces exactly one sample.
- State machine, two states:
  - `ACCUM` (reset state).
  - `REPORT`.
- In `ACCUM`, on `accept`:
  - `acc += cost_in`.
  - `max_run = max(max_run, cost_in)`.
  - `sample_count++`.
- The accumulator is `COST_WIDTH + $clog2(BATCH_SIZE)` bits wide, unsigned, and cannot overflow.
- Batch end: `accept` while `sample_count == BATCH_SIZE-1`. On that edge:
  - `avg_cost <= (acc + cost_in) >> $clog2(BATCH_SIZE)`. This is a truncating shift, not rounded.
  - `max_cost <= max(max_run, cost_in)`.
  - `converged` uses the new average, compared with `<=` against `threshold`.
  - `acc`, `max_run` and `sample_count` return to 0.
  - State goes to `REPORT`.
- In `REPORT`:
  - `batch_ready` is 1.
  - `accept` without `batch_ack`: the sample is dropped and `overrun` is set to 1.
- `batch_ack` in `REPORT`:
  - Next state is `ACCUM`.
  - `overrun` clears to 0.
  - If `accept` occurs in the same cycle, that sample is accepted as the first sample of the new batch (`sample_count` becomes 1).
- `batch_ack` in `ACCUM` is ignored.
- `avg_cost`, `max_cost` and `converged` hold their values from `REPORT` until the next batch end. They are not cleared on ack.

## Timing
- Reset/clear values:
  - `batch_ready`, `avg_cost`, `max_cost`, `converged`, `overrun`, `sample_count`: all 0.
  - State is `ACCUM`.
  - `acc`, `max_run` and `cost_valid_q` are 0.
- Latency: the final sample's `cost_valid` rises before edge k. `batch_ready` and the results are valid after edge k (1 cycle).
- `batch_ready` falls on the edge that samples `batch_ack`=1.
- The earliest next `batch_ready` is `BATCH_SIZE` accepted edges later. Each edge needs `cost_valid` to have been low for at least 1 cycle before it.
- `clear` or `n_rst` low mid-batch or in `REPORT` discards partial and reported results. The first `cost_valid` high after release counts as an edge, because `cost_valid_q` is reset to 0.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- Shared package `cost_pkg` holds:
  - `COST_WIDTH = 8`.
  - `NUM_DIGITS = 10`.
  - The state typedef `acc_state_t {ACCUM, REPORT}`.
- `cost_calculator` imports the same package.
- One sub-module, `rise_detect` (clk, n_rst, clear, in → pulse). It is reusable for other `*_complete` strobes.
- Everything else is one always_ff plus a next-state always_comb.

## Test plan
All scenarios use `BATCH_SIZE=4`.
- Reset: hold `n_rst`=0 for 2 cycles → all outputs 0 and `sample_count`=0.
- Basic batch: pulses with cost 10, 20, 30, 41, `threshold`=30 → `batch_ready`=1 one cycle after the 4th edge, `avg_cost`=25 (101>>2), `max_cost`=41, `converged`=1. Then `batch_ack` → `batch_ready`=0 and the outputs hold.
- Held level: `cost_valid` high for 5 cycles with cost 160 → `sample_count`=1 only. Complete the batch with 160, 160, 160 → `avg_cost`=160, `max_cost`=160, `converged`=0 with `threshold`=100.
- Overrun: while in `REPORT`, send a pulse with no ack → `overrun`=1 and `sample_count` stays 0. Then ack → `overrun`=0.
- Simultaneous ack and edge: `batch_ack` and a `cost_valid` rise in the same cycle, cost 7 → state `ACCUM`, `sample_count`=1, `overrun`=0. The next batch of 7, 0, 0, 0 → `avg_cost`=1, `max_cost`=7.
- Mid-batch clear: after 2 samples, pulse `clear` → `sample_count`=0. A subsequent full batch of 4,4,4,4 → `avg_cost`=4, which proves no residue from the earlier samples.

Source files
------------

// File: rtl/cost_pkg.sv
// Shared constants and types for the training cost datapath
// (cost_calculator and batch_cost_accumulator).
package cost_pkg;

  localparam int COST_WIDTH = 8;
  localparam int NUM_DIGITS = 10;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } acc_state_t;

endpackage

// File: rtl/batch_cost_accumulator_if.sv
// Cost-in / batch-result bundle between cost_calculator, the accumulator
// and the training controller.
interface batch_cost_accumulator_if #(
  parameter int BATCH_SIZE = 16
);
  import cost_pkg::*;

  localparam int CNT_W = $clog2(BATCH_SIZE);

  logic                  cost_valid;
  logic [COST_WIDTH-1:0] cost_in;
  logic [COST_WIDTH-1:0] threshold;
  logic                  batch_ack;
  logic                  batch_ready;
  logic [COST_WIDTH-1:0] avg_cost;
  logic [COST_WIDTH-1:0] max_cost;
  logic                  converged;
  logic                  overrun;
  logic [CNT_W-1:0]      sample_count;

  modport master (
    output cost_valid, cost_in, threshold, batch_ack,
    input  batch_ready, avg_cost, max_cost, converged, overrun, sample_count
  );

  modport slave (
    input  cost_valid, cost_in, threshold, batch_ack,
    output batch_ready, avg_cost, max_cost, converged, overrun, sample_count
  );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector for *_complete strobes: a held level yields one pulse.
module rise_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic in_d;

  always_comb begin
    in_d = in;
  end

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/batch_cost_accumulator.sv
// Accumulates BATCH_SIZE per-image costs and reports truncated average,
// maximum and convergence, held until the controller acknowledges.
module batch_cost_accumulator #(
  parameter int BATCH_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      clear,
  batch_cost_accumulator_if.slave   bus
);
  import cost_pkg::*;

  localparam int LOG2_BS = $clog2(BATCH_SIZE);
  localparam int CNT_W   = LOG2_BS;
  localparam int ACC_W   = COST_WIDTH + LOG2_BS;

  function automatic logic [COST_WIDTH-1:0] cost_max(
    input logic [COST_WIDTH-1:0] a,
    input logic [COST_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic accept;

  rise_detect u_rise (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .in    (bus.cost_valid),
    .pulse (accept)
  );

  acc_state_t            state_q,     state_d;
  logic [ACC_W-1:0]      acc_q,       acc_d;
  logic [COST_WIDTH-1:0] max_run_q,   max_run_d;
  logic [CNT_W-1:0]      count_q,     count_d;
  logic [COST_WIDTH-1:0] avg_q,       avg_d;
  logic [COST_WIDTH-1:0] max_cost_q,  max_cost_d;
  logic                  converged_q, converged_d;
  logic                  overrun_q,   overrun_d;

  logic [ACC_W-1:0]      sum;
  logic [COST_WIDTH-1:0] new_max;
  logic [COST_WIDTH-1:0] new_avg;
  logic                  take;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    max_run_d   = max_run_q;
    count_d     = count_q;
    avg_d       = avg_q;
    max_cost_d  = max_cost_q;
    converged_d = converged_q;
    overrun_d   = overrun_q;
    take        = 1'b0;

    sum     = acc_q + ACC_W'(bus.cost_in);
    new_max = cost_max(max_run_q, bus.cost_in);
    new_avg = sum[ACC_W-1:LOG2_BS];

    // An ack frees the result slot in the same cycle, so a coincident edge starts the next batch.
    if (state_q == REPORT) begin
      if (bus.batch_ack) begin
        state_d   = ACCUM;
        overrun_d = 1'b0;
        take      = accept;
      end else if (accept) begin
        overrun_d = 1'b1;
      end
    end else begin
      take = accept;
    end

    if (take) begin
      if (count_q == CNT_W'(BATCH_SIZE - 1)) begin
        avg_d       = new_avg;
        max_cost_d  = new_max;
        converged_d = (new_avg <= bus.threshold);
        acc_d       = '0;
        max_run_d   = '0;
        count_d     = '0;
        state_d     = REPORT;
      end else begin
        acc_d     = sum;
        max_run_d = new_max;
        count_d   = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      max_run_q   <= '0;
      count_q     <= '0;
      avg_q       <= '0;
      max_cost_q  <= '0;
      converged_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      max_run_q   <= max_run_d;
      count_q     <= count_d;
      avg_q       <= avg_d;
      max_cost_q  <= max_cost_d;
      converged_q <= converged_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.batch_ready  = (state_q == REPORT);
  assign bus.avg_cost     = avg_q;
  assign bus.max_cost     = max_cost_q;
  assign bus.converged    = converged_q;
  assign bus.overrun      = overrun_q;
  assign bus.sample_count = count_q;

endmodule

// File: tb/tb_batch_cost_accumulator.sv
// Directed and randomized bench for batch_cost_accumulator with BATCH_SIZE=4,
// checked against a queue-based batch model.
module tb_batch_cost_accumulator;
  import cost_pkg::*;

  localparam int BS = 4;

  logic clk = 1'b0;
  logic n_rst;
  logic clear;
  int   errors = 0;
  int   checks = 0;

  batch_cost_accumulator_if #(.BATCH_SIZE(BS)) bus ();

  batch_cost_accumulator #(.BATCH_SIZE(BS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: costs of the open batch, plus the last reported result.
  int q[$];
  bit m_prev  = 1'b0;
  bit m_ready = 1'b0;
  bit m_over  = 1'b0;
  bit m_conv  = 1'b0;
  int m_avg   = 0;
  int m_max   = 0;

  task automatic model_step();
    bit edge_seen;
    int sum;
    int mx;
    if (!n_rst || clear) begin
      q.delete();
      m_prev = 1'b0; m_ready = 1'b0; m_over = 1'b0; m_conv = 1'b0;
      m_avg = 0; m_max = 0;
      return;
    end
    edge_seen = bus.cost_valid && !m_prev;
    m_prev    = bus.cost_valid;
    if (m_ready) begin
      if (bus.batch_ack) begin
        m_ready = 1'b0;
        m_over  = 1'b0;
      end else if (edge_seen) begin
        m_over    = 1'b1;
        edge_seen = 1'b0;
      end
    end
    if (edge_seen) begin
      q.push_back(int'(bus.cost_in));
      if (q.size() == BS) begin
        sum = 0;
        mx  = 0;
        foreach (q[i]) begin
          sum += q[i];
          if (q[i] > mx) mx = q[i];
        end
        m_avg   = sum / BS;
        m_max   = mx;
        m_conv  = (m_avg <= int'(bus.threshold));
        m_ready = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("model_batch_ready",  32'(bus.batch_ready),  32'(m_ready));
    check("model_avg_cost",     32'(bus.avg_cost),     32'(m_avg));
    check("model_max_cost",     32'(bus.max_cost),     32'(m_max));
    check("model_converged",    32'(bus.converged),    32'(m_conv));
    check("model_overrun",      32'(bus.overrun),      32'(m_over));
    check("model_sample_count", 32'(bus.sample_count), 32'(q.size()));
  endtask

  task automatic step(input logic v, input logic [COST_WIDTH-1:0] c, input logic ack);
    bus.cost_valid = v;
    bus.cost_in    = c;
    bus.batch_ack  = ack;
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic pulse(input logic [COST_WIDTH-1:0] c);
    step(1'b1, c, 1'b0);
    step(1'b0, c, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0;
    clear = 1'b0;
    bus.cost_valid = 1'b0;
    bus.cost_in    = '0;
    bus.threshold  = '0;
    bus.batch_ack  = 1'b0;

    // Reset held for two cycles
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check("rst_batch_ready",  32'(bus.batch_ready),  32'd0);
    check("rst_avg_cost",     32'(bus.avg_cost),     32'd0);
    check("rst_max_cost",     32'(bus.max_cost),     32'd0);
    check("rst_converged",    32'(bus.converged),    32'd0);
    check("rst_overrun",      32'(bus.overrun),      32'd0);
    check("rst_sample_count", 32'(bus.sample_count), 32'd0);
    n_rst = 1'b1;

    // Basic batch
    bus.threshold = 8'd30;
    pulse(8'd10);
    pulse(8'd20);
    pulse(8'd30);
    check("basic_ready_early", 32'(bus.batch_ready), 32'd0);
    step(1'b1, 8'd41, 1'b0);
    check("basic_ready",     32'(bus.batch_ready), 32'd1);
    check("basic_avg",       32'(bus.avg_cost),    32'd25);
    check("basic_max",       32'(bus.max_cost),    32'd41);
    check("basic_converged", 32'(bus.converged),   32'd1);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    check("ack_ready",     32'(bus.batch_ready), 32'd0);
    check("ack_avg_hold",  32'(bus.avg_cost),    32'd25);
    check("ack_max_hold",  32'(bus.max_cost),    32'd41);
    check("ack_conv_hold", 32'(bus.converged),   32'd1);

    // Held level counts once
    bus.threshold = 8'd100;
    repeat (5) step(1'b1, 8'd160, 1'b0);
    check("held_count", 32'(bus.sample_count), 32'd1);
    step(1'b0, 8'd160, 1'b0);
    pulse(8'd160);
    pulse(8'd160);
    step(1'b1, 8'd160, 1'b0);
    check("held_ready",     32'(bus.batch_ready), 32'd1);
    check("held_avg",       32'(bus.avg_cost),    32'd160);
    check("held_max",       32'(bus.max_cost),    32'd160);
    check("held_converged", 32'(bus.converged),   32'd0);
    step(1'b0, 8'd0, 1'b0);

    // Overrun while waiting for ack
    step(1'b1, 8'd99, 1'b0);
    check("ovr_set",   32'(bus.overrun),      32'd1);
    check("ovr_count", 32'(bus.sample_count), 32'd0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    check("ovr_clear",       32'(bus.overrun),     32'd0);
    check("ovr_ready_clear", 32'(bus.batch_ready), 32'd0);

    // Ack and edge in the same cycle
    pulse(8'd50);
    pulse(8'd60);
    pulse(8'd70);
    pulse(8'd80);
    check("sim_pre_ready", 32'(bus.batch_ready), 32'd1);
    step(1'b1, 8'd7, 1'b1);
    check("sim_ready",   32'(bus.batch_ready),  32'd0);
    check("sim_count",   32'(bus.sample_count), 32'd1);
    check("sim_overrun", 32'(bus.overrun),      32'd0);
    step(1'b0, 8'd0, 1'b0);
    pulse(8'd0);
    pulse(8'd0);
    step(1'b1, 8'd0, 1'b0);
    check("sim_avg", 32'(bus.avg_cost), 32'd1);
    check("sim_max", 32'(bus.max_cost), 32'd7);
    step(1'b0, 8'd0, 1'b1);

    // Mid-batch clear leaves no residue
    pulse(8'd200);
    pulse(8'd200);
    clear = 1'b1;
    step(1'b0, 8'd0, 1'b0);
    clear = 1'b0;
    check("clr_count", 32'(bus.sample_count), 32'd0);
    pulse(8'd4);
    pulse(8'd4);
    pulse(8'd4);
    step(1'b1, 8'd4, 1'b0);
    check("clr_avg",   32'(bus.avg_cost),    32'd4);
    check("clr_max",   32'(bus.max_cost),    32'd4);
    check("clr_ready", 32'(bus.batch_ready), 32'd1);

    // Clear in REPORT with cost_valid held high across release
    clear = 1'b1;
    step(1'b1, 8'd9, 1'b0);
    clear = 1'b0;
    check("clr_rep_ready", 32'(bus.batch_ready), 32'd0);
    check("clr_rep_avg",   32'(bus.avg_cost),    32'd0);
    step(1'b1, 8'd9, 1'b0);
    check("clr_rep_edge", 32'(bus.sample_count), 32'd1);
    step(1'b0, 8'd0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) bus.threshold = 8'($urandom);
      clear = ($urandom_range(0, 59) == 0);
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0));
    end
    clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
